// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single-port memory shared by fetch (IF) and the MEM stage.
// Optional macro MEM_ARB_RR_EN: round-robin on conflicts instead of fixed MEM-over-IF priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_be,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_done,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_be,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_mem_q, owner_mem_d;
  logic             prio_mem;
  logic             grant_mem, grant_if;
  logic             rd_done;

`ifdef MEM_ARB_RR_EN
  // Remembers whether the most recent grant went to MEM; consulted only on conflicts.
  logic last_mem_q;
  always_ff @(posedge clk) begin
    if (rst)         last_mem_q <= 1'b0;
    else if (ram_en) last_mem_q <= grant_mem;
  end
  assign prio_mem = ~last_mem_q;
`else
  assign prio_mem = 1'b1;
`endif

  assign grant_mem = !rst && (state_q == IDLE) && mem_req && (!if_req || prio_mem);
  assign grant_if  = !rst && (state_q == IDLE) && if_req && !grant_mem;
  assign rd_done   = !rst && (state_q == RD_WAIT) && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_mem_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_mem_q <= owner_mem_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_mem_d = owner_mem_q;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_be      = '0;
    ram_addr    = '0;
    ram_wdata   = '0;
    if_done     = 1'b0;
    mem_done    = 1'b0;
    if_rdata    = '0;
    mem_rdata   = '0;
    if (grant_mem) begin
      ram_en    = 1'b1;
      ram_we    = mem_we;
      ram_be    = mem_be;
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
      if (mem_we) begin
        mem_done = 1'b1;
      end else begin
        owner_mem_d = 1'b1;
        cnt_d       = CNT_W'(RD_LAT);
        state_d     = RD_WAIT;
      end
    end else if (grant_if) begin
      ram_en      = 1'b1;
      ram_be      = {BE_W{1'b1}};
      ram_addr    = if_addr;
      owner_mem_d = 1'b0;
      cnt_d       = CNT_W'(RD_LAT);
      state_d     = RD_WAIT;
    end
    if (!rst && state_q == RD_WAIT) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      // A zero count here can only come from corruption; fall back to IDLE rather than lock up.
      if (cnt_q <= CNT_W'(1)) state_d = IDLE;
    end
    if (rd_done) begin
      if (owner_mem_q) begin
        mem_done  = 1'b1;
        mem_rdata = ram_rdata;
      end else begin
        if_done  = 1'b1;
        if_rdata = ram_rdata;
      end
    end
  end

  assign stall_if  = !rst && if_req && !if_done;
  assign stall_mem = !rst && mem_req && !mem_done;

endmodule
